// File: rtl/alu_serial_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_serial_seq_if
//  Description : Request/response bus between the execute stage (master) and
//                the bit-serial ALU sequencer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_serial_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry_out;
  logic             overflow;
  logic             bad_op;

  modport master (
    output start, alu_ctl, opa, opb,
    input  busy, done, result, zero, carry_out, overflow, bad_op
  );

  modport slave (
    input  start, alu_ctl, opa, opb,
    output busy, done, result, zero, carry_out, overflow, bad_op
  );
endinterface
`default_nettype wire

// File: rtl/alu_serial_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_serial_seq
//  Description : Bit-serial sequencer driving a single combinational alu_1bit
//                slice one bit per clock, LSB first, with internal carry
//                chaining and final result/flag assembly.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_seq #(
  parameter int WIDTH = 16
) (
  input  wire logic       clk,
  input  wire logic       reset,
  alu_serial_seq_if.slave bus,
  output logic            slice_a,
  output logic            slice_b,
  output logic            slice_ainvert,
  output logic            slice_binvert,
  output logic            slice_cin,
  output logic [1:0]      slice_aluop,
  input  wire logic       slice_rez,
  input  wire logic       slice_cout
);

  localparam int              c_kw   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_kw-1:0] c_last = c_kw'(WIDTH - 1);
  localparam logic [c_kw-1:0] c_one  = c_kw'(1);

  // Supported {ainvert, binvert, aluop} codes
  localparam logic [3:0] c_and = 4'b0000;
  localparam logic [3:0] c_or  = 4'b0001;
  localparam logic [3:0] c_add = 4'b0010;
  localparam logic [3:0] c_sub = 4'b0110;
  localparam logic [3:0] c_nor = 4'b1100;
  localparam logic [3:0] c_slt = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_ctl;
  logic [c_kw-1:0]  r_k;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_bad_op;

  logic             w_accept;
  logic             w_last;
  logic             w_is_slt;
  logic             w_is_arith;
  logic             w_valid;
  logic [WIDTH-1:0] w_res_full;
  logic [WIDTH-1:0] w_final;

  assign w_accept   = (r_state == IDLE) && bus.start;
  assign w_last     = (r_k == c_last);
  assign w_is_slt   = (r_ctl == c_slt);
  assign w_is_arith = (r_ctl == c_add) || (r_ctl == c_sub);
  assign w_valid    = (r_ctl == c_and) || (r_ctl == c_or) || (r_ctl == c_nor) ||
                      w_is_arith || w_is_slt;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and slice drives; the slice is idle outside RUN
  always_comb begin
    w_state_next  = r_state;
    slice_a       = 1'b0;
    slice_b       = 1'b0;
    slice_ainvert = 1'b0;
    slice_binvert = 1'b0;
    slice_cin     = 1'b0;
    slice_aluop   = 2'b00;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        slice_a       = r_a[r_k];
        slice_b       = r_b[r_k];
        slice_ainvert = r_ctl[3];
        slice_binvert = r_ctl[2];
        // SLT runs as a subtract; any other aluop=11 is an unsupported code
        // and is driven as AND so the slice never sees the 'less' select.
        if (r_ctl[1:0] == 2'b11) begin
          slice_aluop = w_is_slt ? 2'b10 : 2'b00;
        end else begin
          slice_aluop = r_ctl[1:0];
        end
        // Bit 0 takes binvert as carry-in so SUB/SLT get the +1 of two's complement
        slice_cin = (r_k == '0) ? r_ctl[2] : r_carry;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Final-bit result assembly; during the MSB cycle slice_cin is the carry
  // into the MSB, slice_cout the final carry and slice_rez the sign bit.
  always_comb begin
    w_res_full            = r_res;
    w_res_full[WIDTH-1]   = slice_rez;
    w_final               = '0;
    if (w_valid) begin
      if (w_is_slt) begin
        w_final[0] = slice_rez ^ (slice_cin ^ slice_cout);
      end else begin
        w_final = w_res_full;
      end
    end
  end

  // Operand capture, bit-serial accumulation and result/flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_ctl       <= '0;
      r_k         <= '0;
      r_res       <= '0;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_bad_op    <= 1'b0;
    end else if (w_accept) begin
      r_a         <= bus.opa;
      r_b         <= bus.opb;
      r_ctl       <= bus.alu_ctl;
      r_k         <= '0;
      r_res       <= '0;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_bad_op    <= 1'b0;
    end else if (r_state == RUN) begin
      r_res[r_k] <= slice_rez;
      r_carry    <= slice_cout;
      r_k        <= r_k + c_one;
      if (w_last) begin
        r_result    <= w_final;
        r_zero      <= (w_final == '0);
        r_carry_out <= w_is_arith & slice_cout;
        r_overflow  <= w_is_arith & (slice_cin ^ slice_cout);
        r_bad_op    <= ~w_valid;
      end
    end
  end

  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == DONE);
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.carry_out = r_carry_out;
  assign bus.overflow  = r_overflow;
  assign bus.bad_op    = r_bad_op;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_serial_seq
//  Description : Self-checking bench for alu_serial_seq with a behavioural
//                alu_1bit slice and an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial_seq;

  localparam int WIDTH = 16;

  logic       clk;
  logic       reset;
  logic       slice_a, slice_b, slice_ainvert, slice_binvert, slice_cin;
  logic [1:0] slice_aluop;
  logic       slice_rez, slice_cout;
  logic       ea, eb;

  int n_checks;
  int n_errors;

  alu_serial_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .slice_a       (slice_a),
    .slice_b       (slice_b),
    .slice_ainvert (slice_ainvert),
    .slice_binvert (slice_binvert),
    .slice_cin     (slice_cin),
    .slice_aluop   (slice_aluop),
    .slice_rez     (slice_rez),
    .slice_cout    (slice_cout)
  );

  // Behavioural alu_1bit
  always_comb begin
    ea         = slice_a ^ slice_ainvert;
    eb         = slice_b ^ slice_binvert;
    slice_cout = (ea & eb) | (ea & slice_cin) | (eb & slice_cin);
    case (slice_aluop)
      2'b00:   slice_rez = ea & eb;
      2'b01:   slice_rez = ea | eb;
      2'b10:   slice_rez = ea ^ eb ^ slice_cin;
      default: slice_rez = 1'b0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference ALU from the operation definitions, full-width arithmetic
  function automatic void ref_op(input logic [3:0] ctl, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] r, output logic z, output logic c,
                                 output logic v, output logic bad);
    logic [16:0] s;
    r = '0; c = 1'b0; v = 1'b0; bad = 1'b0; s = '0;
    case (ctl)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0]; c = s[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'b0110: begin
        s = {1'b0, a} + {1'b0, ~b} + 17'd1;
        r = s[15:0]; c = s[16];
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'b0111: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      default: bad = 1'b1;
    endcase
    z = (r == 16'd0);
  endfunction

  task automatic run_op(input logic [3:0] ctl, input logic [15:0] a, input logic [15:0] b,
                        input bit inject);
    logic [15:0] er;
    logic        ez, ec, ev, eb_bad;
    int          cyc;
    int          busy_n;
    bit          seen;
    ref_op(ctl, a, b, er, ez, ec, ev, eb_bad);
    @(negedge clk);
    bus.start = 1'b1; bus.alu_ctl = ctl; bus.opa = a; bus.opb = b;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.opa     = 16'($urandom);
    bus.opb     = 16'($urandom);
    bus.alu_ctl = 4'($urandom);
    cyc = 0; busy_n = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_n++;
      if (cyc == 1) begin
        check("accept_clears_result", 32'(bus.result), 32'(0));
        check("accept_clears_bad_op", 32'(bus.bad_op), 32'(0));
      end
      if (inject) begin
        bus.start = (cyc == 3) || (cyc == 17);
        bus.opa   = 16'($urandom);
        bus.opb   = 16'($urandom);
      end
      if (bus.done) seen = 1;
    end
    check("done_seen", 32'(seen), 32'(1));
    check("done_latency", 32'(cyc), 32'(WIDTH + 1));
    check("busy_cycles", 32'(busy_n), 32'(WIDTH + 1));
    check("result", 32'(bus.result), 32'(er));
    check("zero", 32'(bus.zero), 32'(ez));
    check("carry_out", 32'(bus.carry_out), 32'(ec));
    check("overflow", 32'(bus.overflow), 32'(ev));
    check("bad_op", 32'(bus.bad_op), 32'(eb_bad));
    @(negedge clk);
    bus.start = 1'b0;
    check("done_one_cycle", 32'(bus.done), 32'(0));
    check("idle_after_done", 32'(bus.busy), 32'(0));
    check("result_hold", 32'(bus.result), 32'(er));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'(0));
    check({tag, "_done"}, 32'(bus.done), 32'(0));
    check({tag, "_result"}, 32'(bus.result), 32'(0));
    check({tag, "_zero"}, 32'(bus.zero), 32'(0));
    check({tag, "_carry_out"}, 32'(bus.carry_out), 32'(0));
    check({tag, "_overflow"}, 32'(bus.overflow), 32'(0));
    check({tag, "_bad_op"}, 32'(bus.bad_op), 32'(0));
    check({tag, "_slice_drv"},
          32'({slice_a, slice_b, slice_ainvert, slice_binvert, slice_cin, slice_aluop}), 32'(0));
  endtask

  initial begin
    logic [3:0]  codes [6];
    logic [15:0] edges [6];
    logic [3:0]  rc;
    logic [15:0] ra, rb;
    int          ndone;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0111};
    edges = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'h5555};
    n_checks = 0; n_errors = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.alu_ctl = '0; bus.opa = '0; bus.opb = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // Directed cases
    run_op(4'b0010, 16'h1234, 16'h0001, 0);
    run_op(4'b0110, 16'h8000, 16'h0001, 0);
    run_op(4'b0110, 16'h0005, 16'h0005, 0);
    run_op(4'b0111, 16'hFFFF, 16'h0001, 0);
    run_op(4'b0111, 16'h7FFF, 16'h8000, 0);
    run_op(4'b1100, 16'h00FF, 16'h0F0F, 0);
    run_op(4'b0000, 16'hF0F0, 16'h0FF0, 0);
    run_op(4'b0001, 16'hF000, 16'h000F, 0);
    run_op(4'b0010, 16'h0F0F, 16'h7070, 1);
    run_op(4'b1111, 16'h1234, 16'h5678, 0);
    run_op(4'b0010, 16'h0001, 16'h0001, 0);

    // Reset during RUN bit 8 aborts the operation
    @(negedge clk);
    bus.start = 1'b1; bus.alu_ctl = 4'b0010; bus.opa = 16'hFFFF; bus.opb = 16'h0100;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check_all_zero("mid_run_reset");
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("no_done_after_reset", 32'(ndone), 32'(0));
    run_op(4'b0010, 16'h0001, 16'h0001, 0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 8) rc = codes[$urandom_range(0, 5)];
      else rc = 4'($urandom);
      ra = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
      run_op(rc, ra, rb, ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
